vga_text_sched: RTL and testbench

VGA_TEXT_SCHED -- requirements
Module: vga_text_sched

---
 rtl/vga_pkg.sv | 29 ++
 rtl/vga_text_clr.sv | 56 +++++
 rtl/vga_text_sched.sv | 132 +++++++++++++
 tb/tb_vga_text_sched.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared VGA timing, text geometry and clear-engine types.
// The clear-engine enum is only referenced when VGA_TEXT_CLR_EN is defined.
package vga_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FRONT  = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BACK   = 48;
  localparam int H_TOTAL  = 800;

  localparam int V_ACTIVE = 480;
  localparam int V_FRONT  = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BACK   = 33;
  localparam int V_TOTAL  = 525;

  localparam int TEXT_COLS = 80;
  localparam int TEXT_ROWS = 30;
  localparam int CHAR_W    = 8;
  localparam int CHAR_H    = 16;

  localparam logic [7:0] BLANK_CHAR = 8'h20;

  typedef enum logic {
    CLR_IDLE,
    CLR_CLEAR
  } clr_state_t;

endpackage

// File: rtl/vga_text_clr.sv
// Clear-screen engine: walks every cell once, yielding to fetch slots.
// Compiled only when VGA_TEXT_CLR_EN is defined.
`ifdef VGA_TEXT_CLR_EN
module vga_text_clr #(
  parameter int CELLS = vga_pkg::TEXT_COLS * vga_pkg::TEXT_ROWS
) (
  input  logic        clk_vga,
  input  logic        reset_n,
  input  logic        clr_req,
  input  logic        stall,
  output logic        clr_busy,
  output logic        clr_we,
  output logic [11:0] clr_addr
);
  import vga_pkg::*;

  localparam logic [11:0] LAST = 12'(CELLS - 1);

  clr_state_t  state;
  logic [11:0] cnt;

  assign clr_we   = (state == CLR_CLEAR) && !stall;
  assign clr_addr = cnt;

  // busy stays up through the cycle that carries the final write
  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      state    <= CLR_IDLE;
      cnt      <= '0;
      clr_busy <= 1'b0;
    end else begin
      unique case (state)
        CLR_IDLE: begin
          cnt      <= '0;
          clr_busy <= clr_req;
          if (clr_req)
            state <= CLR_CLEAR;
        end
        CLR_CLEAR: begin
          clr_busy <= 1'b1;
          if (!stall) begin
            if (cnt == LAST) begin
              cnt   <= '0;
              state <= CLR_IDLE;
            end else begin
              cnt <= cnt + 12'd1;
            end
          end
        end
        default: state <= CLR_IDLE;
      endcase
    end
  end

endmodule
`endif

// File: rtl/vga_text_sched.sv
// Char-RAM scheduler: scan-out fetches, host writes and optional clear.
// Define VGA_TEXT_CLR_EN to build in the clear-screen engine.
module vga_text_sched #(
  parameter int         TEXT_COLS  = vga_pkg::TEXT_COLS,
  parameter int         TEXT_ROWS  = vga_pkg::TEXT_ROWS,
  parameter logic [7:0] BLANK_CHAR = vga_pkg::BLANK_CHAR
) (
  input  logic        clk_vga,
  input  logic        reset_n,
  input  logic [9:0]  h_count,
  input  logic [9:0]  v_count,
  input  logic        wr_valid,
  output logic        wr_ready,
  input  logic [11:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic        wr_err,
  input  logic        clr_req,
  output logic        clr_busy,
  output logic [11:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_wdata,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  char_code
);
  import vga_pkg::*;

  localparam int          CELLS     = TEXT_COLS * TEXT_ROWS;
  localparam logic [9:0]  H_LAST    = 10'(H_ACTIVE - 2 * CHAR_W);
  localparam logic [9:0]  H_WRAP    = 10'(H_TOTAL - CHAR_W);
  localparam logic [9:0]  V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [9:0]  V_ACT     = 10'(V_ACTIVE);
  localparam logic [11:0] CELLS_LIM = 12'(CELLS);

  logic        slot_in;
  logic        slot_wrap;
  logic        slot_vld;
  logic [9:0]  line;
  logic [6:0]  col;
  logic [11:0] fetch_addr;
  logic        wr_acc;
  logic        wr_oor;
  logic        clr_we;
  logic [11:0] clr_addr;
  logic        fetch_q;
  logic        rd_q;
  logic        cap_vld;
  logic [7:0]  cap;

  // Each slot prefetches the next cell; h=792 fetches col 0 of next line
  always_comb begin
    slot_in   = (h_count[2:0] == 3'd0) && (h_count <= H_LAST);
    slot_wrap = (h_count == H_WRAP);
    col       = 7'd0;
    line      = v_count;
    if (slot_wrap)
      line = (v_count == V_LAST) ? 10'd0 : v_count + 10'd1;
    else
      col = h_count[9:3] + 7'd1;
    slot_vld   = (slot_in || slot_wrap) && (line < V_ACT);
    fetch_addr = 12'(line[8:4]) * 12'(TEXT_COLS) + 12'(col);
  end

  assign wr_ready = !slot_vld && !clr_busy;
  assign wr_acc   = wr_valid && wr_ready;
  assign wr_oor   = wr_addr >= CELLS_LIM;

`ifdef VGA_TEXT_CLR_EN
  vga_text_clr #(
    .CELLS(CELLS)
  ) u_clr (
    .clk_vga  (clk_vga),
    .reset_n  (reset_n),
    .clr_req  (clr_req),
    .stall    (slot_vld),
    .clr_busy (clr_busy),
    .clr_we   (clr_we),
    .clr_addr (clr_addr)
  );
`else
  logic unused_clr_req;
  assign unused_clr_req = clr_req;
  assign clr_busy       = 1'b0;
  assign clr_we         = 1'b0;
  assign clr_addr       = '0;
`endif

  always_ff @(posedge clk_vga or negedge reset_n) begin
    if (!reset_n) begin
      ram_addr  <= '0;
      ram_we    <= 1'b0;
      ram_wdata <= '0;
      wr_err    <= 1'b0;
      char_code <= '0;
      fetch_q   <= 1'b0;
      rd_q      <= 1'b0;
      cap_vld   <= 1'b0;
      cap       <= '0;
    end else begin
      ram_we <= 1'b0;
      wr_err <= 1'b0;
      unique case (1'b1)
        slot_vld: ram_addr <= fetch_addr;
        wr_acc: begin
          if (wr_oor) begin
            wr_err <= 1'b1;
          end else begin
            ram_we    <= 1'b1;
            ram_addr  <= wr_addr;
            ram_wdata <= wr_data;
          end
        end
        clr_we: begin
          ram_we    <= 1'b1;
          ram_addr  <= clr_addr;
          ram_wdata <= BLANK_CHAR;
        end
        default: ;
      endcase
      fetch_q <= slot_vld;
      rd_q    <= fetch_q;
      // code waits in cap until the last pixel of the previous cell
      if (rd_q) begin
        cap     <= ram_rdata;
        cap_vld <= 1'b1;
      end else if (cap_vld && h_count[2:0] == 3'd7) begin
        char_code <= cap;
        cap_vld   <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_vga_text_sched.sv
// Directed bench for vga_text_sched: fetch table, write/err cases, clear.
// Clear-engine sequences follow the VGA_TEXT_CLR_EN build setting.
module tb_vga_text_sched;

  logic        clk_vga = 1'b0;
  logic        reset_n = 1'b0;
  logic [9:0]  h_count = 10'd0;
  logic [9:0]  v_count = 10'd0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [11:0] wr_addr = 12'd0;
  logic [7:0]  wr_data = 8'd0;
  logic        wr_err;
  logic        clr_req = 1'b0;
  logic        clr_busy;
  logic [11:0] ram_addr;
  logic        ram_we;
  logic [7:0]  ram_wdata;
  logic [7:0]  ram_rdata;
  logic [7:0]  char_code;

  logic [7:0]  mem [0:4095];
  logic        pl_we = 1'b0;
  logic [11:0] pl_addr = 12'd0;
  logic [7:0]  pl_data = 8'd0;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [9:0]  h;
    logic [9:0]  v;
    logic        rdy;
    logic        fetch;
    logic [11:0] addr;
  } vec_t;

  vec_t tbl [13];

  always #20 clk_vga = ~clk_vga;

  vga_text_sched dut (
    .clk_vga   (clk_vga),
    .reset_n   (reset_n),
    .h_count   (h_count),
    .v_count   (v_count),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .wr_err    (wr_err),
    .clr_req   (clr_req),
    .clr_busy  (clr_busy),
    .ram_addr  (ram_addr),
    .ram_we    (ram_we),
    .ram_wdata (ram_wdata),
    .ram_rdata (ram_rdata),
    .char_code (char_code)
  );

  always @(posedge clk_vga) begin
    if (pl_we)
      mem[pl_addr] <= pl_data;
    else if (ram_we)
      mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_vga);
    #1;
    if (h_count == 10'd799) begin
      h_count = 10'd0;
      v_count = (v_count == 10'd524) ? 10'd0 : v_count + 10'd1;
    end else begin
      h_count = h_count + 10'd1;
    end
  endtask

  task automatic jump(input logic [9:0] h, input logic [9:0] v);
    @(posedge clk_vga);
    #1;
    h_count = h;
    v_count = v;
  endtask

  function automatic logic [12:0] fetch_of(input logic [9:0] h,
                                           input logic [9:0] v);
    logic [12:0] r;
    int c;
    int l;
    r = '0;
    c = -1;
    l = 0;
    if (h[2:0] == 3'd0 && h <= 10'd624) begin
      c = int'(h) / 8 + 1;
      l = int'(v);
    end else if (h == 10'd792) begin
      c = 0;
      l = (int'(v) + 1) % 525;
    end
    if (c >= 0 && l < 480)
      r = {1'b1, 12'((l / 16) * 80 + c)};
    return r;
  endfunction

  initial begin
    logic [11:0] last_addr;
    logic [11:0] a0;
    logic [12:0] f;
    int wb, rb, ab, bb, sb, fb, nexp, last_i, drop_i;
    logic done, ps, pulsed, hit;

    tbl[0]  = '{10'd0,   10'd0,   1'b0, 1'b1, 12'd1};
    tbl[1]  = '{10'd8,   10'd16,  1'b0, 1'b1, 12'd82};
    tbl[2]  = '{10'd624, 10'd479, 1'b0, 1'b1, 12'd2399};
    tbl[3]  = '{10'd632, 10'd0,   1'b1, 1'b0, 12'd0};
    tbl[4]  = '{10'd792, 10'd15,  1'b0, 1'b1, 12'd80};
    tbl[5]  = '{10'd792, 10'd524, 1'b0, 1'b1, 12'd0};
    tbl[6]  = '{10'd792, 10'd479, 1'b1, 1'b0, 12'd0};
    tbl[7]  = '{10'd792, 10'd478, 1'b0, 1'b1, 12'd2320};
    tbl[8]  = '{10'd3,   10'd10,  1'b1, 1'b0, 12'd0};
    tbl[9]  = '{10'd0,   10'd480, 1'b1, 1'b0, 12'd0};
    tbl[10] = '{10'd0,   10'd200, 1'b0, 1'b1, 12'd961};
    tbl[11] = '{10'd312, 10'd100, 1'b0, 1'b1, 12'd520};
    tbl[12] = '{10'd616, 10'd0,   1'b0, 1'b1, 12'd78};

    // preload through the RAM model while reset is held
    h_count = 10'd700;
    pl_we = 1'b1;
    pl_addr = 12'd80;
    pl_data = 8'h48;
    @(posedge clk_vga);
    #1;
    pl_addr = 12'd81;
    pl_data = 8'h49;
    @(posedge clk_vga);
    #1;
    pl_we = 1'b0;

    @(negedge clk_vga);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_ram_we", ram_we, 0);
    chk("rst_ram_wdata", ram_wdata, 0);
    chk("rst_char_code", char_code, 0);
    chk("rst_wr_err", wr_err, 0);
    chk("rst_clr_busy", clr_busy, 0);
    chk("rst_wr_ready", wr_ready, 1);
    reset_n = 1'b1;

    last_addr = 12'd0;
    for (int i = 0; i < 13; i++) begin
      jump(tbl[i].h, tbl[i].v);
      @(negedge clk_vga);
      chk($sformatf("tbl%0d_ready", i), wr_ready, tbl[i].rdy);
      jump(10'd700, 10'd0);
      @(negedge clk_vga);
      chk($sformatf("tbl%0d_we", i), ram_we, 0);
      if (tbl[i].fetch)
        last_addr = tbl[i].addr;
      chk($sformatf("tbl%0d_addr", i), ram_addr, last_addr);
    end

    // cell 0 of row 1 fetched in the h=792 slot of line 15
    jump(10'd790, 10'd15);
    for (int i = 0; i < 26; i++) begin
      step();
      @(negedge clk_vga);
      if (v_count == 10'd15 && h_count == 10'd793) begin
        chk("row1_fetch_addr", ram_addr, 80);
        chk("row1_fetch_we", ram_we, 0);
      end
      if (v_count == 10'd16 && h_count < 10'd8)
        chk($sformatf("cc_col0_h%0d", h_count), char_code, 8'h48);
      if (v_count == 10'd16 && h_count >= 10'd8 && h_count < 10'd16)
        chk($sformatf("cc_col1_h%0d", h_count), char_code, 8'h49);
    end

    // host write held across a fetch slot
    jump(10'd7, 10'd0);
    step();
    wr_valid = 1'b1;
    wr_addr = 12'd5;
    wr_data = 8'h41;
    @(negedge clk_vga);
    chk("wr_ready_slot_h8", wr_ready, 0);
    step();
    @(negedge clk_vga);
    chk("wr_ready_h9", wr_ready, 1);
    chk("fetch_addr_h9", ram_addr, 2);
    chk("fetch_we_h9", ram_we, 0);
    step();
    wr_valid = 1'b0;
    @(negedge clk_vga);
    chk("wr_we_h10", ram_we, 1);
    chk("wr_addr_h10", ram_addr, 5);
    chk("wr_data_h10", ram_wdata, 8'h41);

    // out-of-range write, then last valid cell
    step();
    wr_valid = 1'b1;
    wr_addr = 12'd2400;
    wr_data = 8'h77;
    @(negedge clk_vga);
    chk("oor_ready", wr_ready, 1);
    step();
    wr_addr = 12'd2399;
    wr_data = 8'h5A;
    @(negedge clk_vga);
    chk("oor_err_pulse", wr_err, 1);
    chk("oor_no_we", ram_we, 0);
    chk("oor_addr_hold", ram_addr, 5);
    chk("w2399_ready", wr_ready, 1);
    step();
    wr_valid = 1'b0;
    @(negedge clk_vga);
    chk("oor_err_one_cycle", wr_err, 0);
    chk("w2399_we", ram_we, 1);
    chk("w2399_addr", ram_addr, 2399);
    chk("w2399_data", ram_wdata, 8'h5A);
    step();
    @(negedge clk_vga);
    chk("mem5", mem[5], 8'h41);
    chk("mem2399", mem[2399], 8'h5A);

    // vertical blanking: no fetches, always ready
    wb = 0;
    rb = 0;
    ab = 0;
    a0 = 12'd0;
    jump(10'd0, 10'd480);
    for (int i = 0; i < 2400; i++) begin
      @(negedge clk_vga);
      if (i == 0)
        a0 = ram_addr;
      if (ram_we) wb++;
      if (!wr_ready) rb++;
      if (ram_addr != a0) ab++;
      step();
    end
    jump(10'd0, 10'd522);
    for (int i = 0; i < 1600; i++) begin
      @(negedge clk_vga);
      if (ram_we) wb++;
      if (!wr_ready) rb++;
      if (ram_addr != a0) ab++;
      step();
    end
    chk("vblank_no_we", wb, 0);
    chk("vblank_ready", rb, 0);
    chk("vblank_addr_hold", ab, 0);

`ifdef VGA_TEXT_CLR_EN
    // host write in the same cycle as clr_req lands first
    jump(10'd700, 10'd0);
    wr_valid = 1'b1;
    wr_addr = 12'd100;
    wr_data = 8'h55;
    clr_req = 1'b1;
    @(negedge clk_vga);
    chk("clr_host_ready", wr_ready, 1);
    step();
    wr_valid = 1'b0;
    clr_req = 1'b0;
    @(negedge clk_vga);
    chk("clr_host_we", ram_we, 1);
    chk("clr_host_addr", ram_addr, 100);
    chk("clr_host_data", ram_wdata, 8'h55);
    chk("clr_busy_set", clr_busy, 1);

    nexp = 0;
    sb = 0;
    fb = 0;
    rb = 0;
    last_i = -100;
    drop_i = -1;
    done = 1'b0;
    pulsed = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      f = fetch_of(h_count, v_count);
      ps = f[12];
      step();
      clr_req = (nexp == 500) && !pulsed;
      if (clr_req) pulsed = 1'b1;
      @(negedge clk_vga);
      if (ram_we) begin
        if (ram_addr != 12'(nexp) || ram_wdata != 8'h20) sb++;
        if (ps) fb++;
        if (ram_addr == 12'd2399) last_i = i;
        nexp++;
      end
      if (clr_busy && wr_ready) rb++;
      if (!clr_busy) begin
        done = 1'b1;
        drop_i = i;
      end
    end
    clr_req = 1'b0;
    chk("clr_finished", done, 1);
    chk("clr_write_count", nexp, 2400);
    chk("clr_sequence", sb, 0);
    chk("clr_fetch_collide", fb, 0);
    chk("clr_ready_low", rb, 0);
    chk("clr_busy_drop", drop_i, last_i + 1);

    // reset mid-clear aborts it for good
    jump(10'd700, 10'd0);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk_vga);
      if (ram_we && ram_addr == 12'd1000)
        hit = 1'b1;
      else
        step();
    end
    chk("abort_reached_1000", hit, 1);
    reset_n = 1'b0;
    #1;
    chk("abort_ram_addr", ram_addr, 0);
    chk("abort_ram_we", ram_we, 0);
    chk("abort_ram_wdata", ram_wdata, 0);
    chk("abort_char_code", char_code, 0);
    chk("abort_wr_err", wr_err, 0);
    chk("abort_clr_busy", clr_busy, 0);
    step();
    step();
    @(negedge clk_vga);
    reset_n = 1'b1;
    wb = 0;
    bb = 0;
    rb = 0;
    for (int i = 0; i < 1500; i++) begin
      step();
      @(negedge clk_vga);
      f = fetch_of(h_count, v_count);
      if (ram_we) wb++;
      if (clr_busy) bb++;
      if (wr_ready !== !f[12]) rb++;
    end
    chk("abort_no_writes", wb, 0);
    chk("abort_busy_low", bb, 0);
    chk("abort_ready_rule", rb, 0);
`else
    // without the engine clr_req has no effect
    jump(10'd700, 10'd0);
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
    wb = 0;
    bb = 0;
    rb = 0;
    for (int i = 0; i < 900; i++) begin
      @(negedge clk_vga);
      f = fetch_of(h_count, v_count);
      if (ram_we) wb++;
      if (clr_busy) bb++;
      if (wr_ready !== !f[12]) rb++;
      step();
    end
    chk("noclr_no_writes", wb, 0);
    chk("noclr_busy_low", bb, 0);
    chk("noclr_ready_rule", rb, 0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
